// File: rtl/ifu_fetch_if.sv
// ----------------------------------------------------------------------------
// ifu_fetch_if : instruction-memory read channel between the fetch unit and
//                instruction memory.
//   imem_req_o   fetch -> mem  read request, held until imem_ack_i
//   imem_addr_o  fetch -> mem  word-aligned fetch address
//   imem_ack_i   mem -> fetch  read completed this cycle (may coincide with req)
//   imem_rdata_i mem -> fetch  instruction word, valid with imem_ack_i
// Modports: master (fetch unit), slave (memory).
// ----------------------------------------------------------------------------
interface ifu_fetch_if;
   localparam int unsigned XLEN = 32;

   logic            imem_req_o;
   logic [XLEN-1:0] imem_addr_o;
   logic            imem_ack_i;
   logic [XLEN-1:0] imem_rdata_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_ack_i,
      input  imem_rdata_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_ack_i,
      output imem_rdata_i
   );
endinterface

// File: rtl/ifu_fetch.sv
// ----------------------------------------------------------------------------
// ifu_fetch : instruction fetch unit. Issues one outstanding read at a time to
//             instruction memory and buffers returned words in a 2-entry FIFO
//             of {pc, inst} pairs whose head is presented to decode.
// Ports:
//   clk             clock, rising edge
//   rst             asynchronous active-low reset
//   stall_i         decode not ready; head entry is not consumed
//   branch_flag_i   one-cycle redirect request
//   branch_target_i redirect address (low two bits ignored)
//   imem            ifu_fetch_if.master instruction-memory read channel
//   pc_o / inst_o   head entry (zero when FIFO empty)
//   inst_valid_o    FIFO not empty
//   bubble_cnt_o    (IFU_PERF_EN only) saturating count of decode-ready
//                   cycles with no valid instruction
// Optional feature macro: IFU_PERF_EN
// ----------------------------------------------------------------------------
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_i,
   ifu_fetch_if.master imem,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        inst_valid_o
`ifdef IFU_PERF_EN
   ,
   output logic [31:0] bubble_cnt_o
`endif
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } state_e;

   state_e                       state_q, state_d;
   logic [XLEN-1:0]              fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]              req_addr_q, req_addr_d;
   logic                         req_q, req_d;
   logic                         head_q, head_d;
   logic [CNT_W-1:0]             count_q, count_d;
   logic [1:0][XLEN-1:0]         ent_pc_q;
   logic [1:0][XLEN-1:0]         ent_inst_q;

   logic                         ack_in_req;
   logic                         push;
   logic                         pop;
   logic                         wr_idx;
   logic                         unused_tgt_lo;

   // Target is forced to word alignment, so its low bits are never used.
   assign unused_tgt_lo = ^branch_target_i[1:0];

   // Head entry presented combinationally; zeros when empty.
   assign inst_valid_o = (count_q != CNT_W'(0));
   assign pc_o         = inst_valid_o ? ent_pc_q[head_q]   : '0;
   assign inst_o       = inst_valid_o ? ent_inst_q[head_q] : '0;

   assign imem.imem_req_o  = req_q;
   assign imem.imem_addr_o = req_addr_q;

   // Only an ack to a live (non-dropped) request can be pushed; a redirect
   // in the same cycle discards it.
   assign ack_in_req = (state_q == REQ) & imem.imem_ack_i;
   assign push       = ack_in_req & ~branch_flag_i;
   assign pop        = inst_valid_o & ~stall_i;
   assign wr_idx     = head_q ^ count_q[0];

   // Next-state: FIFO bookkeeping, fetch pointer and request FSM.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      head_d     = head_q;
      count_d    = count_q;
      req_d      = req_q;
      req_addr_d = req_addr_q;

      if (branch_flag_i) begin
         // Redirect flushes the FIFO and wins over any pop or push.
         count_d    = CNT_W'(0);
         fetch_pc_d = {branch_target_i[XLEN-1:2], 2'b00};
      end else begin
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
         if (pop) begin
            head_d = ~head_q;
         end
         if (push) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
         end
      end

      unique case (state_q)
         IDLE: begin
            // Uses the post-edge count so a pop restarts fetch without a gap.
            if (count_d < CNT_W'(2)) begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (imem.imem_ack_i) begin
               state_d = (count_d < CNT_W'(2)) ? REQ : IDLE;
            end else if (branch_flag_i) begin
               // Request cannot be withdrawn; wait out its ack and discard it.
               state_d = DROP;
            end
         end
         DROP: begin
            if (imem.imem_ack_i) begin
               state_d = REQ;
            end
         end
         default: state_d = IDLE;
      endcase

      req_d = (state_d != IDLE);
      // While dropping, the old address stays on the bus until its ack.
      req_addr_d = (state_d == DROP) ? req_addr_q : fetch_pc_d;
   end

   // State and FIFO registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         req_addr_q <= RESET_PC;
         req_q      <= 1'b0;
         head_q     <= 1'b0;
         count_q    <= CNT_W'(0);
         ent_pc_q   <= '0;
         ent_inst_q <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_addr_q <= req_addr_d;
         req_q      <= req_d;
         head_q     <= head_d;
         count_q    <= count_d;
         if (push) begin
            ent_pc_q[wr_idx]   <= req_addr_q;
            ent_inst_q[wr_idx] <= imem.imem_rdata_i;
         end
      end
   end

`ifdef IFU_PERF_EN
   logic [XLEN-1:0] bubble_cnt_q;

   // Saturating count of cycles where decode was ready but got nothing.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bubble_cnt_q <= '0;
      end else if (!inst_valid_o && !stall_i && (bubble_cnt_q != '1)) begin
         bubble_cnt_q <= bubble_cnt_q + XLEN'(1);
      end
   end

   assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// ----------------------------------------------------------------------------
// tb_ifu_fetch : self-checking bench for ifu_fetch. A transaction-level model
// (queue of {pc, inst}, fetch pointer, outstanding-request flag) is compared
// with the DUT on every falling edge; directed scenarios add literal checks.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ifu_fetch;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        br = 1'b0;
   logic [31:0] tgt = '0;
   logic [31:0] pc_o, inst_o;
   logic        valid;
   logic        force_ack = 1'b0;
   int          lat = 0;
   int          wait_cnt;
   int          ack_cnt;
`ifdef IFU_PERF_EN
   logic [31:0] bubble_cnt;
`endif

   int vecs = 0;
   int errs = 0;

   ifu_fetch_if mem ();

   ifu_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk             (clk),
      .rst             (rst),
      .stall_i         (stall),
      .branch_flag_i   (br),
      .branch_target_i (tgt),
      .imem            (mem.master),
      .pc_o            (pc_o),
      .inst_o          (inst_o),
      .inst_valid_o    (valid)
`ifdef IFU_PERF_EN
      ,
      .bubble_cnt_o    (bubble_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Memory: acks after 'lat' waiting cycles; data is address + 1.
   assign mem.imem_ack_i   = force_ack | (mem.imem_req_o && (wait_cnt >= lat));
   assign mem.imem_rdata_i = mem.imem_addr_o + 32'd1;

   always @(posedge clk or negedge rst) begin
      if (!rst) wait_cnt <= 0;
      else if (mem.imem_req_o && !mem.imem_ack_i) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
   end

   always @(posedge clk) begin
      if (rst && mem.imem_req_o && mem.imem_ack_i) ack_cnt <= ack_cnt + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_pc, m_addr;
   bit          m_req, m_drop, m_acked, m_popped;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mq.delete();
         m_pc   = RESET_PC;
         m_addr = RESET_PC;
         m_req  = 1'b0;
         m_drop = 1'b0;
      end else begin
         m_acked  = m_req && mem.imem_ack_i;
         m_popped = (mq.size() != 0) && !stall;
         if (br) begin
            mq.delete();
            m_pc = {tgt[31:2], 2'b00};
            if (m_req && !m_acked) m_drop = 1'b1;
            else begin
               m_drop = 1'b0;
               m_req  = 1'b1;
               m_addr = m_pc;
            end
         end else begin
            if (m_popped) void'(mq.pop_front());
            if (m_acked) begin
               if (!m_drop) begin
                  mq.push_back({m_addr, mem.imem_rdata_i});
                  m_pc = m_pc + 32'd4;
               end
               m_drop = 1'b0;
            end
            if (!(m_req && !m_acked)) begin
               m_req  = (mq.size() < 2);
               m_addr = m_pc;
            end
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      chk("valid", 32'(valid), 32'(mq.size() != 0));
      chk("pc",   pc_o,   (mq.size() != 0) ? mq[0].pc   : 32'h0);
      chk("inst", inst_o, (mq.size() != 0) ? mq[0].inst : 32'h0);
      chk("req",  32'(mem.imem_req_o), 32'(m_req));
      if (m_req || !rst) chk("addr", mem.imem_addr_o, m_addr);
   end

   // ---------------- directed helpers ----------------
   task automatic do_reset();
      rst = 1'b0; stall = 1'b0; br = 1'b0; tgt = '0; force_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req",   32'(mem.imem_req_o), 32'h0);
      chk("rst_addr",  mem.imem_addr_o, RESET_PC);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_pc",    pc_o, 32'h0);
      chk("rst_inst",  inst_o, 32'h0);
      ack_cnt = 0;
      rst = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int bound);
      int n = 0;
      while (!valid && n < bound) begin
         step();
         n++;
      end
      chk("wait_valid_timeout", 32'(valid), 32'h1);
   endtask

   logic [15:0] stall_pat = 16'b0011_0000_1110_0100;

   initial begin
      // Zero-wait streaming after reset.
      lat = 0;
      do_reset();
      step();
      chk("first_req",   32'(mem.imem_req_o), 32'h1);
      chk("first_addr",  mem.imem_addr_o, 32'h0);
      chk("first_noval", 32'(valid), 32'h0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stream_pc",   pc_o, 32'(4 * k));
         chk("stream_inst", inst_o, 32'(4 * k + 1));
      end

      // Stall for 10 cycles: FIFO fills with two entries, then requests stop.
      do_reset();
      stall = 1'b1;
      repeat (10) step();
      chk("stall_acks", 32'(ack_cnt), 32'd2);
      chk("stall_req",  32'(mem.imem_req_o), 32'h0);
      chk("stall_pc",   pc_o, 32'h0);
      chk("stall_inst", inst_o, 32'h1);
      stall = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("unstall_valid", 32'(valid), 32'h1);
         chk("unstall_pc", pc_o, 32'(4 * k));
         step();
      end

      // Redirect while a slow request is outstanding.
      lat = 3;
      do_reset();
      step();
      br = 1'b1; tgt = 32'h100;
      step();
      br = 1'b0;
      chk("drop_addr_old", mem.imem_addr_o, 32'h0);
      chk("drop_req",      32'(mem.imem_req_o), 32'h1);
      repeat (3) step();
      chk("drop_addr_new", mem.imem_addr_o, 32'h100);
      chk("drop_noval",    32'(valid), 32'h0);
      wait_valid(20);
      chk("drop_first_pc",   pc_o, 32'h100);
      chk("drop_first_inst", inst_o, 32'h101);

      // Redirect to an unaligned target coinciding with an ack.
      lat = 0;
      do_reset();
      step();
      br = 1'b1; tgt = 32'h203;
      step();
      br = 1'b0;
      chk("sim_addr",  mem.imem_addr_o, 32'h200);
      chk("sim_noval", 32'(valid), 32'h0);
      step();
      chk("sim_pc",   pc_o, 32'h200);
      chk("sim_inst", inst_o, 32'h201);

      // Asynchronous reset with a request pending, then a late ack in IDLE.
      lat = 2;
      do_reset();
      stall = 1'b1;
      wait_valid(20);
      chk("pend_req", 32'(mem.imem_req_o), 32'h1);
      #1 rst = 1'b0;
      #1;
      chk("arst_req",   32'(mem.imem_req_o), 32'h0);
      chk("arst_valid", 32'(valid), 32'h0);
      chk("arst_pc",    pc_o, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      lat = 0; stall = 1'b0; force_ack = 1'b1; rst = 1'b1;
      step();
      force_ack = 1'b0;
      chk("late_req",   32'(mem.imem_req_o), 32'h1);
      chk("late_addr",  mem.imem_addr_o, RESET_PC);
      chk("late_noval", 32'(valid), 32'h0);
      step();
      chk("late_pc",   pc_o, 32'h0);
      chk("late_inst", inst_o, 32'h1);

      // Mixed traffic: varying latency, stall pattern and redirects.
      for (int i = 0; i < 60; i++) begin
         lat   = (i / 15) % 3;
         stall = stall_pat[i % 16];
         br    = ((i % 23) == 7);
         tgt   = 32'h1000 + 32'(i * 8) + 32'h3;
         step();
      end
      br = 1'b0; stall = 1'b0;
      repeat (4) step();

`ifdef IFU_PERF_EN
      // Memory never answers: every cycle is a bubble.
      lat = 100000;
      do_reset();
      repeat (5) @(posedge clk);
      #1;
      chk("bubble_cnt", bubble_cnt, 32'd5);
      lat = 0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
